// File: rtl/ctrl_conv_pkg.sv
// Shared FSM state type and width helpers for the convolution sequencer.
package ctrl_conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FLUSH,
        VALID,
        DONE
    } conv_state_t;

    // Extra bits on window sums so base+stride+f_len never wraps
    localparam int unsigned WIN_MARGIN = 2;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_window_cnt.sv
// Window base / tap index tracking and last-window detection for ctrl_conv_seq.
module conv_window_cnt
    import ctrl_conv_pkg::*;
#(
    parameter int unsigned X_MEM_SIZE = 8,
    parameter int unsigned F_MEM_SIZE = 4,
    localparam int unsigned XW = $clog2(X_MEM_SIZE),
    localparam int unsigned FW = $clog2(F_MEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          k_inc,
    input  logic          next_win,
    input  logic [FW:0]   f_len_q,
    input  logic [XW-1:0] stride_q,
    output logic [XW-1:0] xaddr,
    output logic [FW-1:0] faddr,
    output logic          k_last,
    output logic          last_win
);

    localparam int unsigned WW = XW + WIN_MARGIN;

    logic [XW-1:0] base;
    logic [FW-1:0] k;
    logic [WW-1:0] win_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base <= '0;
            k    <= '0;
        end else if (clear) begin
            base <= '0;
            k    <= '0;
        end else if (next_win) begin
            base <= base + stride_q;
            k    <= '0;
        end else if (k_inc) begin
            k <= k + 1'b1;
        end
    end

    assign win_end  = WW'(base) + WW'(stride_q) + WW'(f_len_q);
    assign last_win = (win_end > WW'(X_MEM_SIZE));
    assign k_last   = ({1'b0, k} == (f_len_q - 1'b1));
    assign xaddr    = base + XW'(k);
    assign faddr    = k;

endmodule

// File: rtl/ctrl_conv_seq.sv
// Sliding-window convolution read/MAC sequencer with valid/ready output handshake.
// Define CTRL_CONV_STRIDE_EN to honour the stride port; otherwise the stride is fixed at 1.
module ctrl_conv_seq
    import ctrl_conv_pkg::*;
#(
    parameter int unsigned X_MEM_SIZE = 8,
    parameter int unsigned F_MEM_SIZE = 4,
    localparam int unsigned XW = $clog2(X_MEM_SIZE),
    localparam int unsigned FW = $clog2(F_MEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          conv_start,
    input  logic [FW:0]   f_len,
    input  logic [XW-1:0] stride,
    input  logic          m_ready_y,
    output logic [XW-1:0] xaddr,
    output logic [FW-1:0] faddr,
    output logic          rd_en,
    output logic          reset_accum,
    output logic          en_accum,
    output logic          m_valid_y,
    output logic          conv_done,
    output logic          cfg_err,
    output logic          busy
);

    localparam int unsigned FLEN_MAX = min_u(F_MEM_SIZE, X_MEM_SIZE);

    conv_state_t   state;
    logic [FW:0]   f_len_q;
    logic [XW-1:0] stride_q;
    logic [XW-1:0] stride_eff;
    logic          f_len_ok;
    logic          start_ok;
    logic          k_inc;
    logic          next_win;
    logic          k_last;
    logic          last_win;

`ifdef CTRL_CONV_STRIDE_EN
    assign stride_eff = (stride == '0) ? XW'(1) : stride;
`else
    logic stride_unused;
    assign stride_unused = ^stride;
    assign stride_eff    = XW'(1);
`endif

    assign f_len_ok = (f_len != '0) && (f_len <= (FW + 1)'(FLEN_MAX));
    assign start_ok = (state == IDLE) && conv_start && f_len_ok;
    assign k_inc    = (state == FETCH) && !k_last;
    assign next_win = (state == VALID) && m_ready_y && !last_win;

    conv_window_cnt #(
        .X_MEM_SIZE(X_MEM_SIZE),
        .F_MEM_SIZE(F_MEM_SIZE)
    ) u_win (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .k_inc    (k_inc),
        .next_win (next_win),
        .f_len_q  (f_len_q),
        .stride_q (stride_q),
        .xaddr    (xaddr),
        .faddr    (faddr),
        .k_last   (k_last),
        .last_win (last_win)
    );

    // Outputs are set for the state being entered, so each is a plain register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            f_len_q     <= '0;
            stride_q    <= '0;
            rd_en       <= 1'b0;
            reset_accum <= 1'b0;
            en_accum    <= 1'b0;
            m_valid_y   <= 1'b0;
            conv_done   <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            en_accum    <= rd_en;
            reset_accum <= 1'b0;
            conv_done   <= 1'b0;
            cfg_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (conv_start) begin
                        if (f_len_ok) begin
                            f_len_q     <= f_len;
                            stride_q    <= stride_eff;
                            rd_en       <= 1'b1;
                            reset_accum <= 1'b1;
                            busy        <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            cfg_err   <= 1'b1;
                            conv_done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (k_last) begin
                        rd_en <= 1'b0;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    m_valid_y <= 1'b1;
                    state     <= VALID;
                end
                VALID: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (last_win) begin
                            conv_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rd_en       <= 1'b1;
                            reset_accum <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_conv_seq.sv
// Self-checking bench for ctrl_conv_seq against a window-list reference model.
module tb_ctrl_conv_seq;

    localparam int X_MEM = 8;
    localparam int F_MEM = 4;
    localparam int XW    = 3;
    localparam int FW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          conv_start = 1'b0;
    logic [FW:0]   f_len = '0;
    logic [XW-1:0] stride = '0;
    logic          m_ready_y = 1'b0;
    logic [XW-1:0] xaddr;
    logic [FW-1:0] faddr;
    logic          rd_en, reset_accum, en_accum, m_valid_y, conv_done, cfg_err, busy;
    logic [6:0]    ctl;

    int vectors = 0;
    int miscompares = 0;

    ctrl_conv_seq #(.X_MEM_SIZE(8), .F_MEM_SIZE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .conv_start  (conv_start),
        .f_len       (f_len),
        .stride      (stride),
        .m_ready_y   (m_ready_y),
        .xaddr       (xaddr),
        .faddr       (faddr),
        .rd_en       (rd_en),
        .reset_accum (reset_accum),
        .en_accum    (en_accum),
        .m_valid_y   (m_valid_y),
        .conv_done   (conv_done),
        .cfg_err     (cfg_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // {rd_en, reset_accum, en_accum, m_valid_y, conv_done, cfg_err, busy}
    assign ctl = {rd_en, reset_accum, en_accum, m_valid_y, conv_done, cfg_err, busy};

    function automatic int eff_stride(input int st);
`ifdef CTRL_CONV_STRIDE_EN
        return (st == 0) ? 1 : st;
`else
        return 1;
`endif
    endfunction

    // mode 0: always ready; 1: random ready; 2: ready withheld for 3 VALID cycles
    task automatic run_conv(input int fl, input int st, input int mode, input bit poke, output int n_out);
        int  bases[$];
        int  s, lat, tries;
        bit  rdy, first;
        s = eff_stride(st);
        for (int b = 0; b + fl <= X_MEM; b += s) bases.push_back(b);
        n_out = 0; lat = 0; first = 1'b1;
        f_len = (FW + 1)'(fl); stride = XW'(st); conv_start = 1'b1;
        @(posedge clk); #1;
        foreach (bases[w]) begin
            for (int j = 0; j < fl; j++) begin
                conv_start = poke && (w == 0) && (j == fl - 1);
                m_ready_y  = 1'($urandom % 2);
                @(negedge clk); lat++;
                vectors++;
                if (ctl !== {1'b1, j == 0, j != 0, 4'b0001} || xaddr !== XW'(bases[w] + j) || faddr !== FW'(j)) begin
                    miscompares++;
                    $display("FAIL fetch w%0d j%0d: ctl=%b xaddr=%0d faddr=%0d, expected ctl=%b xaddr=%0d faddr=%0d",
                             w, j, ctl, xaddr, faddr, {1'b1, j == 0, j != 0, 4'b0001}, bases[w] + j, j);
                end
                @(posedge clk); #1;
            end
            conv_start = 1'b0;
            m_ready_y  = 1'($urandom % 2);
            @(negedge clk); lat++;
            vectors++;
            if (ctl !== 7'b0010001) begin
                miscompares++;
                $display("FAIL flush w%0d: ctl=%b expected 0010001", w, ctl);
            end
            @(posedge clk); #1;
            tries = 0; rdy = 1'b0;
            while (!rdy) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom % 2 == 1) || (tries >= 5);
                    default: rdy = (tries >= 3);
                endcase
                m_ready_y  = rdy;
                conv_start = poke && (tries == 0);
                @(negedge clk); lat++;
                if (first) begin
                    vectors++;
                    if (lat !== fl + 2) begin
                        miscompares++;
                        $display("FAIL latency: first m_valid_y after %0d cycles, expected %0d", lat, fl + 2);
                    end
                    first = 1'b0;
                end
                vectors++;
                if (ctl !== 7'b0001001 || xaddr !== XW'(bases[w] + fl - 1) || faddr !== FW'(fl - 1)) begin
                    miscompares++;
                    $display("FAIL valid w%0d t%0d: ctl=%b xaddr=%0d faddr=%0d, expected ctl=0001001 xaddr=%0d faddr=%0d",
                             w, tries, ctl, xaddr, faddr, bases[w] + fl - 1, fl - 1);
                end
                if (rdy) n_out++;
                tries++;
                @(posedge clk); #1;
            end
        end
        conv_start = poke;
        m_ready_y  = 1'($urandom % 2);
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b0000101) begin
            miscompares++;
            $display("FAIL done: ctl=%b expected 0000101", ctl);
        end
        @(posedge clk); #1;
        conv_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b0000000) begin
            miscompares++;
            $display("FAIL post_done: ctl=%b expected 0000000", ctl);
        end
        vectors++;
        if (n_out !== bases.size()) begin
            miscompares++;
            $display("FAIL out_count: got %0d outputs, expected %0d", n_out, bases.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b0 || xaddr !== '0 || faddr !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ctl=%b xaddr=%0d faddr=%0d, expected all 0", ctl, xaddr, faddr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_release: busy=%b expected 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        run_conv(4, 1, 0, 1'b0, n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL basic_count: got %0d expected 5", n);
        end
    endtask

    task automatic test_backpressure();
        int n;
        run_conv(2, 1, 2, 1'b0, n);
        vectors++;
        if (n !== 7) begin
            miscompares++;
            $display("FAIL backpressure_count: got %0d expected 7", n);
        end
    endtask

    task automatic test_stride();
        int n, exp_n;
`ifdef CTRL_CONV_STRIDE_EN
        exp_n = 2;
`else
        exp_n = 6;
`endif
        run_conv(3, 3, 0, 1'b0, n);
        vectors++;
        if (n !== exp_n) begin
            miscompares++;
            $display("FAIL stride_count: got %0d expected %0d", n, exp_n);
        end
    endtask

    task automatic test_cfg_err();
        int bad[3] = '{0, 5, 7};
        foreach (bad[i]) begin
            f_len = (FW + 1)'(bad[i]); stride = 3'd1; conv_start = 1'b1;
            @(posedge clk); #1;
            conv_start = 1'b0;
            @(negedge clk);
            vectors++;
            if (ctl !== 7'b0000110) begin
                miscompares++;
                $display("FAIL cfg_err f_len=%0d: ctl=%b expected 0000110", bad[i], ctl);
            end
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                vectors++;
                if (ctl !== 7'b0) begin
                    miscompares++;
                    $display("FAIL cfg_err_quiet f_len=%0d c%0d: ctl=%b expected 0000000", bad[i], c, ctl);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        f_len = 3'd4; stride = 3'd1; conv_start = 1'b1;
        @(posedge clk); #1;
        conv_start = 1'b0;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (ctl !== 7'b0 || xaddr !== '0 || faddr !== '0) begin
            miscompares++;
            $display("FAIL async_reset: ctl=%b xaddr=%0d faddr=%0d, expected all 0", ctl, xaddr, faddr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: ctl=%b expected 0000000", ctl);
        end
        @(posedge clk); #1;
        run_conv(4, 1, 1, 1'b0, n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL reset_rerun_count: got %0d expected 5", n);
        end
    endtask

    task automatic test_busy_start();
        int n;
        run_conv(3, 2, 1, 1'b1, n);
        vectors++;
        if (n !== (X_MEM - 3) / eff_stride(2) + 1) begin
            miscompares++;
            $display("FAIL busy_start_count: got %0d expected %0d", n, (X_MEM - 3) / eff_stride(2) + 1);
        end
    endtask

    task automatic test_random();
        int n, fl, st;
        for (int i = 0; i < 6; i++) begin
            fl = int'($urandom_range(1, 4));
            st = int'($urandom_range(0, 7));
            run_conv(fl, st, 1, 1'($urandom % 2), n);
            vectors++;
            if (n !== (X_MEM - fl) / eff_stride(st) + 1) begin
                miscompares++;
                $display("FAIL random_count fl=%0d st=%0d: got %0d expected %0d",
                         fl, st, n, (X_MEM - fl) / eff_stride(st) + 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stride();
        test_cfg_err();
        test_reset_mid();
        test_busy_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_conv_seq.md
CTRL_CONV_SEQ -- requirements
Module: ctrl_conv_seq

Interface
REQ-001 SHALL have parameter X_MEM_SIZE, default 8, meaning input-vector memory depth in words.
REQ-002 SHALL have parameter F_MEM_SIZE, default 4, meaning maximum filter length in words.
REQ-003 SHALL derive local widths XW = $clog2(X_MEM_SIZE) and FW = $clog2(F_MEM_SIZE).
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- conv_start  in  1  start pulse; sampled only in IDLE.
- f_len  in  FW+1  runtime filter length; latched at start.
- stride  in  XW  runtime window stride; latched at start.
- m_ready_y  in  1  downstream ready.
- xaddr  out  XW  x-memory read address.
- faddr  out  FW  f-memory read address.
- rd_en  out  1  memory read enable.
- reset_accum  out  1  clear MAC accumulator.
- en_accum  out  1  MAC accumulate enable.
- m_valid_y  out  1  output valid.
- conv_done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle illegal-configuration pulse.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement an FSM with states IDLE, FETCH, FLUSH, VALID and DONE.
REQ-006 SHALL, in IDLE with conv_start=1 and 1<=f_len<=min(F_MEM_SIZE,X_MEM_SIZE), latch f_len and stride, set base=0, k=0, and go to FETCH.
REQ-007 SHALL, in IDLE with conv_start=1 and f_len illegal, pulse cfg_err and conv_done together in the next cycle, with no fetch and no m_valid_y, then remain in IDLE.
REQ-008 SHALL, in FETCH, drive rd_en=1, xaddr=base+k and faddr=k, and increment k once per cycle; the cycle with k=f_len-1 is the last FETCH cycle and goes to FLUSH.
REQ-009 SHALL pulse reset_accum=1 in the first FETCH cycle of every window.
REQ-010 SHALL drive en_accum as rd_en delayed by one cycle (1-cycle memory read latency); en_accum is therefore high in FETCH cycles 2..f_len and in FLUSH.
REQ-011 SHALL go from FLUSH to VALID; m_valid_y=1 for exactly the VALID state; latency from the conv_start sample to the first m_valid_y is f_len+2 cycles.
REQ-012 SHALL hold VALID while m_ready_y=0, with rd_en, en_accum and reset_accum all 0 and the addresses frozen.
REQ-013 SHALL, on m_valid_y & m_ready_y, go to DONE if base+stride+f_len > X_MEM_SIZE, else set base+=stride, k=0 and go to FETCH (next window; no idle cycle).
REQ-014 SHALL pulse conv_done for exactly one cycle in DONE, then return to IDLE.
REQ-015 SHALL ignore conv_start outside IDLE.
REQ-016 SHALL treat stride=0 as stride=1.
REQ-017 SHALL compute window arithmetic at XW+2 bits so that base+stride+f_len cannot wrap.
REQ-018 SHALL produce floor((X_MEM_SIZE-f_len)/stride)+1 outputs per convolution.
REQ-019 SHALL ignore m_ready_y outside VALID.

Reset
REQ-020 SHALL, on reset assertion at any time including mid-window, force IDLE asynchronously with every output at 0, base=0 and k=0.
REQ-021 SHALL leave IDLE only after reset is released, on a sampled conv_start.

Configuration
REQ-022 SHALL honour the stride input only when CTRL_CONV_STRIDE_EN is defined.
REQ-023 SHALL, when CTRL_CONV_STRIDE_EN is undefined, hard-wire the effective stride to 1, ignore the stride port, and keep the port list unchanged.

Structure
REQ-024 SHALL take the FSM state enum typedef and the width helper constants from the shared package ctrl_conv_pkg.
REQ-025 SHALL place the base/k address tracking and the last-window compare in the sub-module conv_window_cnt; the FSM and handshake logic stay in ctrl_conv_seq.

Verification
All scenarios use X_MEM_SIZE=8 and F_MEM_SIZE=4.
REQ-026 SHALL cover: f_len=4, stride=1, m_ready_y=1 -> 5 outputs; first m_valid_y 6 cycles after start; conv_done one cycle after the 5th handshake.
REQ-027 SHALL cover: m_ready_y held 0 for 3 cycles in VALID -> m_valid_y held; xaddr and faddr frozen; en_accum=0; no reset_accum.
REQ-028 SHALL cover: f_len=3, stride=3 -> windows at base 0 and 3, 2 outputs with STRIDE_EN defined; 6 outputs without it.
REQ-029 SHALL cover: f_len=0 and f_len=5 -> cfg_err=1 and conv_done=1 in the cycle after start; m_valid_y never asserted.
REQ-030 SHALL cover: reset asserted mid-FETCH -> outputs 0 immediately without a clock edge; a new conv_start after release runs a full convolution correctly.
REQ-031 SHALL cover: conv_start pulsed while busy=1 -> ignored; output count unchanged.
